cdb_arbiter: RTL
================

# cdb_arbiter

- Single-writer arbiter for the common data bus (CDB) shared by the ALU reservation station and the load/store buffer (LSB).
- Buffers each producer's completion broadcasts in a small per-source FIFO and grants one per cycle, round-robin.
- Drives the single registered broadcast consumed by the reorder buffer, reservation station and LSB operand wakeup.
- Removes the same-cycle multi-broadcast collisions the ROB must otherwise resolve.

## Interface
Parameters:
- DEPTH, 2, entries per source FIFO; power of two, ≥2.
- ENTRY_W, 5, width of ROB entry tag.

Ports:
- clk_in  input  1  system clock; all state on posedge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global pause when low.
- roll_back  input  1  misprediction flush.
- alu_valid  input  1  ALU result offered this cycle.
- alu_result  input  32  ALU result value.
- alu_pc  input  32  ALU branch target / next-pc result.
- alu_entry  input  ENTRY_W  ROB tag of the ALU result.
- alu_ready  output  1  ALU FIFO can accept; registered.
- lsb_valid  input  1  LSB completion offered.
- lsb_result  input  32  load data (don't-care for stores).
- lsb_entry  input  ENTRY_W  ROB tag of the LSB completion.
- lsb_store  input  1  completion is a store-address-ready, not a load.
- lsb_ready  output  1  LSB FIFO can accept; registered.
- cdb_valid  output  1  broadcast valid.
- cdb_result  output  32  broadcast value.
- cdb_pc  output  32  pc result (0 for LSB grants).
- cdb_entry  output  ENTRY_W  broadcast ROB tag.
- cdb_src  output  1  0 = ALU, 1 = LSB.
- cdb_store  output  1  broadcast is store-address-ready.
- err_overflow  output  1  sticky; valid offered while ready low.

## Operation
- Per-source FIFO: circular, head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
- Enqueue: occurs when valid && ready && rdy_in && !roll_back.
- ready is computed from the registered count: ready = (count < DEPTH).
  - A dequeue in the same cycle does not free the slot until the next cycle.
  - With both sides active, count is unchanged.
- Overflow: valid while ready low means the request is dropped and err_overflow is set. Only reset clears it.
- Arbitration, combinational over the FIFO heads:
  - Only one head non-empty: that source wins.
  - Both heads non-empty: the source not recorded in last_grant wins.
  - last_grant is updated on every grant.
- Grant: the winning head is popped and its fields are registered onto the cdb_* outputs with cdb_valid=1.
- No grant: cdb_valid=0; the other cdb_* fields hold their previous values.
- roll_back, synchronous, takes priority over everything except reset:
  - both FIFOs emptied;
  - cdb_valid=0 at that edge;
  - inputs that cycle ignored;
  - last_grant unchanged;
  - err_overflow unchanged.
- rdy_in low: no enqueue, no dequeue, cdb_valid cleared at that edge, all other state held. Producers must hold requests until ready and rdy_in are both high.
- Reset (rst_in low, asynchronous, immediate):
  - FIFOs empty.
  - All cdb_* outputs are 0.
  - alu_ready=1 and lsb_ready=1 once released.
  - err_overflow=0.
  - last_grant=LSB, so the ALU wins the first tie.
  - Reset asserted mid-broadcast drops all buffered results.

## Timing
- Latency from valid to broadcast is 2 cycles with no contention: request in cycle k → enqueued at end of k → arbitrated in k+1 → cdb_valid high in k+2.
- Each lost tie adds one cycle.
- Throughput: one broadcast per cycle in aggregate.
- Under sustained contention each source gets ≥1 grant every 2 cycles.
- cdb_valid is high for exactly one cycle per grant; a result is never broadcast twice.
- ready deasserts in the cycle after the enqueue that fills the FIFO.

## Configuration
- LSB_PRIORITY_EN defined: fixed priority; the LSB always wins ties, and last_grant is still maintained but unused. Loads complete first, at the cost of possible ALU starvation bounded only by the LSB issue rate.
- LSB_PRIORITY_EN undefined: round-robin as above (default build).

## Test plan
- Single request: reset, alu_valid=1 for one cycle, alu_result=0x1234, alu_entry=3 → cdb_valid=1 exactly 2 cycles later with cdb_result=0x1234, cdb_entry=3, cdb_src=0; it never repeats.
- Tie and back-to-back: ALU (entry 1) and LSB (entry 2, lsb_store=1) requests offered in the same cycle, then new requests on both every cycle for 6 cycles.
  - Round-robin build: grants alternate ALU, LSB, ALU, …, starting with the ALU; the first LSB grant has cdb_store=1 and cdb_pc=0.
  - LSB_PRIORITY_EN build: the LSB takes every tie.
- Full: hold lsb_valid=1 with the ALU also saturating (DEPTH=2) → lsb_ready falls after 2 enqueues. Then force lsb_valid while lsb_ready=0 → err_overflow=1 and stays 1; the dropped tag never appears on the CDB.
- Flush: fill both FIFOs, pulse roll_back → next cycle cdb_valid=0, both readies=1, and no stale tag is broadcast afterward.
- Pause: rdy_in low for 3 cycles with both FIFOs non-empty → cdb_valid=0 throughout and FIFO contents preserved; broadcasts resume in original order after rdy_in rises.
- Async reset: assert rst_in low mid-cycle while cdb_valid=1 → outputs go to 0 before the next clock edge.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: single-writer arbiter for the common data bus.
// The ALU and LSB completions are each buffered in a small circular FIFO.
// One head is granted per cycle onto a registered broadcast.
// Ties between the two heads normally go round-robin via last_grant.
// Optional feature macro: LSB_PRIORITY_EN. When it is defined, the LSB wins
// every tie and last_grant is still tracked but not consulted.
module cdb_arbiter #(
    parameter int DEPTH   = 2,
    parameter int ENTRY_W = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               roll_back,
    input  logic               alu_valid,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        alu_pc,
    input  logic [ENTRY_W-1:0] alu_entry,
    output logic               alu_ready,
    input  logic               lsb_valid,
    input  logic [31:0]        lsb_result,
    input  logic [ENTRY_W-1:0] lsb_entry,
    input  logic               lsb_store,
    output logic               lsb_ready,
    output logic               cdb_valid,
    output logic [31:0]        cdb_result,
    output logic [31:0]        cdb_pc,
    output logic [ENTRY_W-1:0] cdb_entry,
    output logic               cdb_src,
    output logic               cdb_store,
    output logic               err_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Packed broadcast record: {result, pc, entry, store}
    localparam int E_W   = 32 + 32 + ENTRY_W + 1;

    // Index 0 is the ALU source, index 1 the LSB source (matches cdb_src).
    logic [1:0]            src_valid;
    logic [1:0][E_W-1:0]   src_data;
    logic [1:0]            src_ready;
    logic [1:0]            src_nonempty;
    logic [1:0]            enq;
    logic [1:0]            deq;
    logic [1:0][E_W-1:0]   head_data;

    logic                  accept;
    logic                  grant;
    logic                  win_lsb;

    logic                  last_grant_reg;   // 1 = LSB was granted last
    logic                  cdb_valid_reg;
    logic                  cdb_src_reg;
    logic [E_W-1:0]        bcast_reg;
    logic                  err_reg;

    assign src_valid   = {lsb_valid, alu_valid};
    assign src_data[0] = {alu_result, alu_pc, alu_entry, 1'b0};
    assign src_data[1] = {lsb_result, 32'd0, lsb_entry, lsb_store};

    // Nothing moves while paused or during a flush.
    assign accept = rdy_in && !roll_back;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [E_W-1:0]   mem [DEPTH];
            logic [PTR_W-1:0] head_reg;
            logic [PTR_W-1:0] tail_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Ready comes from the registered count only, so a same-cycle pop
            // frees its slot one cycle later.
            assign src_ready[gi]    = (cnt_reg < CNT_W'(DEPTH));
            assign src_nonempty[gi] = (cnt_reg != '0);
            assign enq[gi]          = src_valid[gi] && src_ready[gi] && accept;
            assign head_data[gi]    = mem[head_reg];

            // Entry storage; validity is tracked by the count, so no reset needed.
            always_ff @(posedge clk_in) begin
                if (enq[gi]) begin
                    mem[tail_reg] <= src_data[gi];
                end
            end

            // Pointer and occupancy update; a flush empties the FIFO.
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    head_reg <= '0;
                    tail_reg <= '0;
                    cnt_reg  <= '0;
                end else if (roll_back) begin
                    head_reg <= '0;
                    tail_reg <= '0;
                    cnt_reg  <= '0;
                end else if (rdy_in) begin
                    if (enq[gi]) begin
                        tail_reg <= tail_reg + PTR_W'(1);
                    end
                    if (deq[gi]) begin
                        head_reg <= head_reg + PTR_W'(1);
                    end
                    cnt_reg <= cnt_reg + CNT_W'(enq[gi]) - CNT_W'(deq[gi]);
                end
            end
        end
    endgenerate

    // Pick the winning head: a lone non-empty head wins, ties use the policy.
    always_comb begin
        win_lsb = 1'b0;
        case (src_nonempty)
            2'b10:   win_lsb = 1'b1;
`ifdef LSB_PRIORITY_EN
            2'b11:   win_lsb = 1'b1;
`else
            2'b11:   win_lsb = ~last_grant_reg;
`endif
            default: win_lsb = 1'b0;
        endcase
    end

    assign grant = accept && (src_nonempty != 2'b00);
    assign deq   = grant ? (win_lsb ? 2'b10 : 2'b01) : 2'b00;

    // Broadcast register, grant history and sticky overflow flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_reg  <= 1'b0;
            cdb_src_reg    <= 1'b0;
            bcast_reg      <= '0;
            last_grant_reg <= 1'b1;
            err_reg        <= 1'b0;
        end else begin
            cdb_valid_reg <= grant;
            if (grant) begin
                bcast_reg      <= head_data[win_lsb];
                cdb_src_reg    <= win_lsb;
                last_grant_reg <= win_lsb;
            end
            if (accept && ((src_valid & ~src_ready) != 2'b00)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign alu_ready    = src_ready[0];
    assign lsb_ready    = src_ready[1];
    assign cdb_valid    = cdb_valid_reg;
    assign cdb_result   = bcast_reg[E_W-1 -: 32];
    assign cdb_pc       = bcast_reg[E_W-33 -: 32];
    assign cdb_entry    = bcast_reg[ENTRY_W:1];
    assign cdb_store    = bcast_reg[0];
    assign cdb_src      = cdb_src_reg;
    assign err_overflow = err_reg;

endmodule
